// File: rtl/candy_id_pipe.sv
// candy_id_pipe -- registered instruction-decode stage for the candy core.
//
// Takes a 24-bit instruction from fetch and produces its fields for execute:
// the op, the register addresses, the immediate, and flags that say which
// operands are read and whether rd is written (used by hazard logic). The
// handshakes on both sides are valid/ready. A 2-entry skid buffer (the output
// register plus one skid register) lets in_ready come straight from a flop,
// so ready never passes combinationally through this stage.
//
// Parameters
//   OP_W   width of decoded op (>= 6)
//   IMM_W  width of imm_data (>= 15)
//   PC_W   width of the PC carried with each instruction
//
// Ports
//   clk, rst                       clock (rising edge), synchronous active-high reset
//   flush                          drop every held entry (branch redirect)
//   in_valid, in_ready             fetch-side handshake; in_ready is a flop
//   inst, in_pc                    instruction word and its PC
//   out_valid, out_ready           execute-side handshake
//   op, itype                      decoded opcode (zero-extended) and format
//   rs1, rs2, rd                   register addresses
//   rs1_en, rs2_en, rd_we          operand-use / writeback flags
//   imm_data, out_pc               immediate and PC of the bundle
//   illegal                        reserved-field violation
//
// Build option
//   CANDY_ID_ILLEGAL_EN  when defined, an R-type with a nonzero inst[3:0] is
//                        flagged illegal and has rd_we cleared; the bundle is
//                        still delivered so execute can raise the trap. When
//                        undefined, illegal is always 0.

`timescale 1ns/1ps

module candy_id_pipe #(
  parameter int OP_W  = 6,
  parameter int IMM_W = 16,
  parameter int PC_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      inst,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  op,
  output logic [1:0]       itype,
  output logic [3:0]       rs1,
  output logic [3:0]       rs2,
  output logic [3:0]       rd,
  output logic             rs1_en,
  output logic             rs2_en,
  output logic             rd_we,
  output logic [IMM_W-1:0] imm_data,
  output logic [PC_W-1:0]  out_pc,
  output logic             illegal
);

  // The state value is the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [1:0]       itype;
    logic [3:0]       rs1;
    logic [3:0]       rs2;
    logic [3:0]       rd;
    logic             rs1_en;
    logic             rs2_en;
    logic             rd_we;
    logic [IMM_W-1:0] imm;
    logic             illegal;
  } dec_t;

  state_t          state;
  dec_t            dec;
  dec_t            out_q;
  dec_t            skid_q;
  logic [PC_W-1:0] out_pc_q;
  logic [PC_W-1:0] skid_pc_q;
  logic            accept;

  // Decode the incoming word. Every field starts at zero, so fields that a
  // format does not use are zero rather than left over from an earlier word.
  always_comb begin
    dec       = '0;
    dec.itype = inst[23:22];
    case (inst[23:22])
      2'b00: begin
        dec.op     = OP_W'(inst[21:16]);
        dec.rs1    = inst[15:12];
        dec.rs2    = inst[11:8];
        dec.rd     = inst[7:4];
        dec.rs1_en = 1'b1;
        dec.rs2_en = 1'b1;
        dec.rd_we  = 1'b1;
      end
      2'b01: begin
        dec.op     = OP_W'(inst[21:18]);
        dec.rs1    = inst[17:14];
        dec.rd     = inst[13:10];
        dec.imm    = IMM_W'($signed(inst[9:0]));
        dec.rs1_en = 1'b1;
        dec.rd_we  = 1'b1;
      end
      2'b10: begin
        dec.op     = OP_W'(inst[21:18]);
        dec.rs1    = inst[17:14];
        dec.rs2    = inst[13:10];
        dec.imm    = IMM_W'($signed(inst[9:0]));
        dec.rs1_en = 1'b1;
        dec.rs2_en = 1'b1;
      end
      default: begin
        dec.op    = OP_W'(inst[21:19]);
        dec.rd    = inst[18:15];
        dec.imm   = IMM_W'(inst[14:0]);
        dec.rd_we = 1'b1;
      end
    endcase
`ifdef CANDY_ID_ILLEGAL_EN
    // rd_we is cleared so a trapping instruction never writes the register file.
    if (inst[23:22] == 2'b00 && inst[3:0] != 4'h0) begin
      dec.illegal = 1'b1;
      dec.rd_we   = 1'b0;
    end
`endif
  end

  assign accept = in_valid & in_ready;

  // Skid-buffer control. in_ready is loaded with "next state is not FULL",
  // so it is low exactly while both registers are occupied. An entry that
  // arrives while the output register is stalled goes into the skid
  // register, and it moves forward when execute takes the output. Flush and
  // reset drop everything. During reset in_ready is held low, and it rises on
  // the first edge after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_q     <= '0;
      out_pc_q  <= '0;
      skid_q    <= '0;
      skid_pc_q <= '0;
    end else if (flush) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (accept) begin
            out_q    <= dec;
            out_pc_q <= in_pc;
            state    <= ONE;
          end
        end
        ONE: begin
          in_ready <= 1'b1;
          if (accept && out_ready) begin
            out_q    <= dec;
            out_pc_q <= in_pc;
          end else if (accept) begin
            skid_q    <= dec;
            skid_pc_q <= in_pc;
            state     <= FULL;
            in_ready  <= 1'b0;
          end else if (out_ready) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            out_q    <= skid_q;
            out_pc_q <= skid_pc_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid = (state != EMPTY);
  assign op        = out_q.op;
  assign itype     = out_q.itype;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign rd        = out_q.rd;
  assign rs1_en    = out_q.rs1_en;
  assign rs2_en    = out_q.rs2_en;
  assign rd_we     = out_q.rd_we;
  assign imm_data  = out_q.imm;
  assign out_pc    = out_pc_q;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_candy_id_pipe.sv
// tb_candy_id_pipe -- self-checking bench for candy_id_pipe.
// Each accepted instruction has its expected bundle pushed onto a scoreboard
// queue. The bundle is popped and compared when execute takes it.
// Build option: CANDY_ID_ILLEGAL_EN selects the illegal-flag expectations.

`timescale 1ns/1ps

module tb_candy_id_pipe;

  typedef struct packed {
    logic [5:0]  op;
    logic [1:0]  itype;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic        rs1_en;
    logic        rs2_en;
    logic        rd_we;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        illegal;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] inst = '0;
  logic [15:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  op;
  logic [1:0]  itype;
  logic [3:0]  rs1, rs2, rd;
  logic        rs1_en, rs2_en, rd_we;
  logic [15:0] imm_data;
  logic [15:0] out_pc;
  logic        illegal;

  int          checks = 0;
  int          errors = 0;
  bundle_t     sb[$];
  logic        expIr = 1'b0;
  logic        acc;

  always #5 clk = ~clk;

  candy_id_pipe #(.OP_W(6), .IMM_W(16), .PC_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .itype(itype), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_en(rs1_en), .rs2_en(rs2_en), .rd_we(rd_we),
    .imm_data(imm_data), .out_pc(out_pc), .illegal(illegal)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference decoder, built from the instruction formats.
  function automatic bundle_t refDecode(input logic [23:0] w, input logic [15:0] pc);
    bundle_t b;
    b       = '0;
    b.pc    = pc;
    b.itype = w[23:22];
    if (w[23:22] == 2'b00) begin
      b.op = w[21:16]; b.rs1 = w[15:12]; b.rs2 = w[11:8]; b.rd = w[7:4];
      b.rs1_en = 1; b.rs2_en = 1; b.rd_we = 1;
`ifdef CANDY_ID_ILLEGAL_EN
      if (w[3:0] != 0) begin b.illegal = 1; b.rd_we = 0; end
`endif
    end else if (w[23:22] == 2'b01) begin
      b.op = {2'b00, w[21:18]}; b.rs1 = w[17:14]; b.rd = w[13:10];
      b.imm = {{6{w[9]}}, w[9:0]}; b.rs1_en = 1; b.rd_we = 1;
    end else if (w[23:22] == 2'b10) begin
      b.op = {2'b00, w[21:18]}; b.rs1 = w[17:14]; b.rs2 = w[13:10];
      b.imm = {{6{w[9]}}, w[9:0]}; b.rs1_en = 1; b.rs2_en = 1;
    end else begin
      b.op = {3'b000, w[21:19]}; b.rd = w[18:15]; b.imm = {1'b0, w[14:0]}; b.rd_we = 1;
    end
    return b;
  endfunction

  function automatic bundle_t seen();
    return {op, itype, rs1, rs2, rd, rs1_en, rs2_en, rd_we, imm_data, out_pc, illegal};
  endfunction

  // Drive one cycle of inputs at the falling edge. Then check the handshake
  // outputs against the model and update the scoreboard for the next rising edge.
  task automatic applyStimulus(input logic v, input logic [23:0] w, input logic [15:0] pc,
                               input logic ordy, input logic fl, output logic accepted);
    bundle_t e;
    @(negedge clk);
    in_valid = v; inst = w; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    checkOutput("in_ready", 64'(in_ready), 64'(expIr));
    checkOutput("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    accepted = v && in_ready && !fl;
    if (out_valid && ordy) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out", 64'(out_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        checkOutput("bundle", 64'(seen()), 64'(e));
      end
    end
    if (fl) sb.delete();
    else if (accepted) sb.push_back(refDecode(w, pc));
    expIr = (sb.size() != 2);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1; in_valid = 0; flush = 0; out_ready = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
      checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
      checkOutput("rst_outputs", 64'(seen()), 64'(0));
    end
    rst = 0;
    sb.delete();
    expIr = 1;
  endtask

  task automatic sendInst(input logic [23:0] w, input logic [15:0] pc, input logic ordy);
    logic a;
    a = 0;
    for (int k = 0; k < 20 && !a; k++) applyStimulus(1, w, pc, ordy, 0, a);
    checkOutput("send_accepted", 64'(a), 64'(1));
  endtask

  task automatic drain();
    logic a;
    for (int k = 0; k < 20 && sb.size() != 0; k++) applyStimulus(0, '0, '0, 1, 0, a);
    checkOutput("drain_empty", 64'(sb.size()), 64'(0));
    applyStimulus(0, '0, '0, 0, 0, a);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset behaviour, then in_ready one cycle after release
    applyReset();
    applyStimulus(0, '0, '0, 0, 0, acc);

    // R-type decode, one-cycle latency
    applyStimulus(1, 24'h05A570, 16'h0100, 1, 0, acc);
    applyStimulus(0, '0, '0, 0, 0, acc);
    checkOutput("r_op", 64'(op), 64'(6'h05));
    checkOutput("r_regs", 64'({rs1, rs2, rd}), 64'(12'hA57));
    checkOutput("r_flags", 64'({rs1_en, rs2_en, rd_we}), 64'(3'b111));
    checkOutput("r_imm", 64'(imm_data), 64'(0));
    drain();

    // I-type sign extension
    applyStimulus(1, 24'h4BA3FF, 16'h0104, 1, 0, acc);
    applyStimulus(0, '0, '0, 0, 0, acc);
    checkOutput("i_op", 64'(op), 64'(6'h02));
    checkOutput("i_rs1_rd", 64'({rs1, rd}), 64'(8'hE8));
    checkOutput("i_imm", 64'(imm_data), 64'(16'hFFFF));
    checkOutput("i_rs2", 64'({rs2, rs2_en}), 64'(0));
    drain();

    // U-type: rd is inst[18:15] = 4'hE, and the immediate is zero-extended
    applyStimulus(1, 24'hFF7FFF, 16'h0108, 1, 0, acc);
    applyStimulus(0, '0, '0, 0, 0, acc);
    checkOutput("u_op", 64'(op), 64'(6'h07));
    checkOutput("u_rd", 64'(rd), 64'(4'hE));
    checkOutput("u_imm", 64'(imm_data), 64'(16'h7FFF));
    checkOutput("u_en", 64'({rs1_en, rs2_en, rd_we}), 64'(3'b001));
    drain();

    // Back-to-back throughput
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 24'($urandom()), 16'(16'h0200 + i), 1, 0, acc);
      checkOutput("tput_accept", 64'(acc), 64'(1));
    end
    drain();

    // Backpressure: two fill the buffer, the third waits, then all drain in order
    sendInst(24'h051230, 16'h0300, 0);
    sendInst(24'h4C0155, 16'h0304, 0);
    applyStimulus(1, 24'h9A4BCD, 16'h0308, 0, 0, acc);
    checkOutput("full_in_ready", 64'(in_ready), 64'(0));
    checkOutput("full_blocked", 64'(acc), 64'(0));
    sendInst(24'h9A4BCD, 16'h0308, 1);
    sendInst(24'hE12345, 16'h030C, 1);
    drain();

    // Flush while full with an instruction offered
    sendInst(24'h020010, 16'h0400, 0);
    sendInst(24'h030020, 16'h0404, 0);
    applyStimulus(1, 24'h040030, 16'h0408, 0, 1, acc);
    applyStimulus(0, '0, '0, 0, 0, acc);
    checkOutput("flush_full_out_valid", 64'(out_valid), 64'(0));
    checkOutput("flush_full_in_ready", 64'(in_ready), 64'(1));

    // Flush while holding one: the instruction offered that cycle is dropped
    sendInst(24'h050040, 16'h0500, 0);
    applyStimulus(1, 24'h060050, 16'h0504, 0, 1, acc);
    applyStimulus(0, '0, '0, 0, 0, acc);
    checkOutput("flush_one_out_valid", 64'(out_valid), 64'(0));

    // Reserved-field check on an R-type
    applyStimulus(1, 24'h010001, 16'h0600, 0, 0, acc);
    applyStimulus(0, '0, '0, 0, 0, acc);
`ifdef CANDY_ID_ILLEGAL_EN
    checkOutput("illegal_flag", 64'({illegal, rd_we}), 64'(2'b10));
`else
    checkOutput("illegal_flag", 64'({illegal, rd_we}), 64'(2'b01));
`endif
    drain();

    // Reset while entries are held discards them
    sendInst(24'h070060, 16'h0700, 0);
    sendInst(24'h080070, 16'h0704, 0);
    applyReset();
    applyStimulus(0, '0, '0, 0, 0, acc);

    // Random traffic with occasional flushes
    for (int i = 0; i < 120; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 24'($urandom()), 16'(16'h1000 + i),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), acc);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
